// File: rtl/ga_pkg.sv
// Shared definitions for the gate array configuration controller:
// command encodings and register field widths.
package ga_pkg;

    localparam int PEN_W     = 5;
    localparam int INK_W     = 5;
    localparam int RAM_CFG_W = 6;

    typedef enum logic [1:0] {
        CMD_PEN  = 2'b00,
        CMD_INK  = 2'b01,
        CMD_MODE = 2'b10,
        CMD_RAM  = 2'b11
    } ga_cmd_e;

    localparam logic [PEN_W-1:0] BORDER_PEN_DEF = 5'd16;

endpackage

// File: rtl/ga_io_decode.sv
// Qualifies Z80 I/O writes to the gate array and emits exactly one cmd_valid
// per I/O cycle, on the clk where the qualified write first appears.
module ga_io_decode
    import ga_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iorq_n,
    input  logic                 wr_n,
    input  logic                 m1_n,
    input  logic                 a15,
    input  logic                 a14,
    input  logic [7:0]           d,
    output logic                 cmd_valid,
    output ga_cmd_e              cmd,
    output logic [RAM_CFG_W-1:0] data
);

    logic wr_act;
    logic wr_act_d;
    logic wr_act_q;

    // M1_N low with IORQ_N low is an interrupt acknowledge, not a write.
    always_comb begin
        wr_act    = ~iorq_n & ~wr_n & m1_n & ~a15 & a14;
        wr_act_d  = wr_act;
        cmd_valid = wr_act & ~wr_act_q;
        cmd       = ga_cmd_e'(d[7:6]);
        data      = d[RAM_CFG_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_act_q <= 1'b0;
        end else begin
            wr_act_q <= wr_act_d;
        end
    end

endmodule

// File: rtl/ga_reg_ctrl.sv
// Gate array configuration registers: pen/ink, ROM disables, RAM banking,
// the interrupt-reset pulse and HSYNC-aligned video mode switching.
module ga_reg_ctrl
    import ga_pkg::*;
#(
    parameter bit               RAM_CFG_EN = 1'b1,
    parameter logic [PEN_W-1:0] BORDER_PEN = BORDER_PEN_DEF
) (
    input  logic                 clk,
    input  logic                 RESET_N,
    input  logic                 IORQ_N,
    input  logic                 WR_N,
    input  logic                 M1_N,
    input  logic                 A15,
    input  logic                 A14,
    input  logic [7:0]           D,
    input  logic                 HSYNC_I,
    output logic [PEN_W-1:0]     PEN,
    output logic                 INK_WE,
    output logic [PEN_W-1:0]     INK_ADDR,
    output logic [INK_W-1:0]     INK_DATA,
    output logic [1:0]           MODE,
    output logic                 LROM_DIS,
    output logic                 HROM_DIS,
    output logic                 IRQ_RESET,
    output logic [RAM_CFG_W-1:0] RAM_CFG,
    output logic                 RAM_WE
);

    logic                 cmd_valid;
    ga_cmd_e              cmd;
    logic [RAM_CFG_W-1:0] data;

    ga_io_decode u_dec (
        .clk       (clk),
        .rst_n     (RESET_N),
        .iorq_n    (IORQ_N),
        .wr_n      (WR_N),
        .m1_n      (M1_N),
        .a15       (A15),
        .a14       (A14),
        .d         (D),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .data      (data)
    );

    logic [PEN_W-1:0]     pen_d,       pen_q;
    logic                 ink_we_d,    ink_we_q;
    logic [PEN_W-1:0]     ink_addr_d,  ink_addr_q;
    logic [INK_W-1:0]     ink_data_d,  ink_data_q;
    logic [1:0]           mode_d,      mode_q;
    logic [1:0]           mode_pend_d, mode_pend_q;
    logic                 lrom_dis_d,  lrom_dis_q;
    logic                 hrom_dis_d,  hrom_dis_q;
    logic                 irq_reset_d, irq_reset_q;
    logic [RAM_CFG_W-1:0] ram_cfg_d,   ram_cfg_q;
    logic                 ram_we_d,    ram_we_q;
    logic                 hsync_d,     hsync_q;

    always_comb begin
        pen_d       = pen_q;
        ink_we_d    = 1'b0;
        ink_addr_d  = ink_addr_q;
        ink_data_d  = ink_data_q;
        mode_pend_d = mode_pend_q;
        lrom_dis_d  = lrom_dis_q;
        hrom_dis_d  = hrom_dis_q;
        irq_reset_d = 1'b0;
        ram_cfg_d   = ram_cfg_q;
        ram_we_d    = 1'b0;
        hsync_d     = HSYNC_I;

        // mode_pend_q here is the pre-write value, so a write landing on an
        // HSYNC edge is deferred to the following HSYNC.
        mode_d = (HSYNC_I && !hsync_q) ? mode_pend_q : mode_q;

        if (cmd_valid) begin
            case (cmd)
                CMD_PEN: begin
                    pen_d = data[4] ? BORDER_PEN : {1'b0, data[3:0]};
                end
                CMD_INK: begin
                    ink_we_d   = 1'b1;
                    ink_addr_d = pen_q;
                    ink_data_d = data[INK_W-1:0];
                end
                CMD_MODE: begin
                    mode_pend_d = data[1:0];
                    lrom_dis_d  = data[2];
                    hrom_dis_d  = data[3];
                    irq_reset_d = data[4];
                end
                CMD_RAM: begin
                    if (RAM_CFG_EN) begin
                        ram_cfg_d = data;
                        ram_we_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            pen_q       <= '0;
            ink_we_q    <= 1'b0;
            ink_addr_q  <= '0;
            ink_data_q  <= '0;
            mode_q      <= '0;
            mode_pend_q <= '0;
            lrom_dis_q  <= 1'b0;
            hrom_dis_q  <= 1'b0;
            irq_reset_q <= 1'b0;
            ram_cfg_q   <= '0;
            ram_we_q    <= 1'b0;
            hsync_q     <= 1'b0;
        end else begin
            pen_q       <= pen_d;
            ink_we_q    <= ink_we_d;
            ink_addr_q  <= ink_addr_d;
            ink_data_q  <= ink_data_d;
            mode_q      <= mode_d;
            mode_pend_q <= mode_pend_d;
            lrom_dis_q  <= lrom_dis_d;
            hrom_dis_q  <= hrom_dis_d;
            irq_reset_q <= irq_reset_d;
            ram_cfg_q   <= ram_cfg_d;
            ram_we_q    <= ram_we_d;
            hsync_q     <= hsync_d;
        end
    end

    assign PEN       = pen_q;
    assign INK_WE    = ink_we_q;
    assign INK_ADDR  = ink_addr_q;
    assign INK_DATA  = ink_data_q;
    assign MODE      = mode_q;
    assign LROM_DIS  = lrom_dis_q;
    assign HROM_DIS  = hrom_dis_q;
    assign IRQ_RESET = irq_reset_q;
    assign RAM_CFG   = ram_cfg_q;
    assign RAM_WE    = ram_we_q;

endmodule

// File: tb/tb_ga_reg_ctrl.sv
// Bench for ga_reg_ctrl: one instance with RAM configuration decode, one
// without, driven by the same bus and checked against a cycle model.
module tb_ga_reg_ctrl;

    logic clk = 1'b0;
    logic RESET_N;
    logic IORQ_N, WR_N, M1_N, A15, A14, HSYNC_I;
    logic [7:0] D;

    logic [4:0] PEN, INK_ADDR, INK_DATA, PEN_0, INK_ADDR_0, INK_DATA_0;
    logic       INK_WE, LROM_DIS, HROM_DIS, IRQ_RESET, RAM_WE;
    logic       INK_WE_0, LROM_DIS_0, HROM_DIS_0, IRQ_RESET_0, RAM_WE_0;
    logic [1:0] MODE, MODE_0;
    logic [5:0] RAM_CFG, RAM_CFG_0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ga_reg_ctrl #(.RAM_CFG_EN(1'b1), .BORDER_PEN(5'd16)) dut (
        .clk(clk), .RESET_N(RESET_N), .IORQ_N(IORQ_N), .WR_N(WR_N), .M1_N(M1_N),
        .A15(A15), .A14(A14), .D(D), .HSYNC_I(HSYNC_I),
        .PEN(PEN), .INK_WE(INK_WE), .INK_ADDR(INK_ADDR), .INK_DATA(INK_DATA),
        .MODE(MODE), .LROM_DIS(LROM_DIS), .HROM_DIS(HROM_DIS),
        .IRQ_RESET(IRQ_RESET), .RAM_CFG(RAM_CFG), .RAM_WE(RAM_WE)
    );

    ga_reg_ctrl #(.RAM_CFG_EN(1'b0), .BORDER_PEN(5'd16)) dut0 (
        .clk(clk), .RESET_N(RESET_N), .IORQ_N(IORQ_N), .WR_N(WR_N), .M1_N(M1_N),
        .A15(A15), .A14(A14), .D(D), .HSYNC_I(HSYNC_I),
        .PEN(PEN_0), .INK_WE(INK_WE_0), .INK_ADDR(INK_ADDR_0), .INK_DATA(INK_DATA_0),
        .MODE(MODE_0), .LROM_DIS(LROM_DIS_0), .HROM_DIS(HROM_DIS_0),
        .IRQ_RESET(IRQ_RESET_0), .RAM_CFG(RAM_CFG_0), .RAM_WE(RAM_WE_0)
    );

    // Reference state: what the controller should show after each clk.
    logic [4:0] m_pen, m_ink_addr, m_ink_data;
    logic       m_ink_we, m_lrom, m_hrom, m_irq, m_ram_we;
    logic [1:0] m_mode, m_pend;
    logic [5:0] m_ram_cfg;
    logic       m_prev_act, m_prev_hs;

    task automatic model_reset();
        m_pen = '0; m_ink_addr = '0; m_ink_data = '0; m_ink_we = 1'b0;
        m_lrom = 1'b0; m_hrom = 1'b0; m_irq = 1'b0; m_ram_we = 1'b0;
        m_mode = '0; m_pend = '0; m_ram_cfg = '0;
        m_prev_act = 1'b0; m_prev_hs = 1'b0;
    endtask

    // Applies one clk worth of the bus rules to the reference state.
    task automatic model_step();
        logic act, ev, hs_rise;
        logic [1:0] new_mode;
        act      = !IORQ_N && !WR_N && M1_N && !A15 && A14;
        ev       = act && !m_prev_act;
        hs_rise  = HSYNC_I && !m_prev_hs;
        new_mode = hs_rise ? m_pend : m_mode;
        m_ink_we = 1'b0; m_irq = 1'b0; m_ram_we = 1'b0;
        if (ev) begin
            if (D[7:6] == 2'd0) begin
                m_pen = D[4] ? 5'd16 : {1'b0, D[3:0]};
            end else if (D[7:6] == 2'd1) begin
                m_ink_we = 1'b1; m_ink_addr = m_pen; m_ink_data = D[4:0];
            end else if (D[7:6] == 2'd2) begin
                m_pend = D[1:0]; m_lrom = D[2]; m_hrom = D[3]; m_irq = D[4];
            end else begin
                m_ram_cfg = D[5:0]; m_ram_we = 1'b1;
            end
        end
        m_mode     = new_mode;
        m_prev_act = act;
        m_prev_hs  = HSYNC_I;
    endtask

    function automatic logic [27:0] dut_vec();
        return {PEN, INK_WE, INK_ADDR, INK_DATA, MODE, LROM_DIS, HROM_DIS,
                IRQ_RESET, RAM_CFG, RAM_WE};
    endfunction

    function automatic logic [27:0] dut0_vec();
        return {PEN_0, INK_WE_0, INK_ADDR_0, INK_DATA_0, MODE_0, LROM_DIS_0,
                HROM_DIS_0, IRQ_RESET_0, RAM_CFG_0, RAM_WE_0};
    endfunction

    function automatic logic [27:0] exp_vec(input bit ram_en);
        return {m_pen, m_ink_we, m_ink_addr, m_ink_data, m_mode, m_lrom, m_hrom,
                m_irq, ram_en ? m_ram_cfg : 6'd0, ram_en ? m_ram_we : 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bus_idle();
        IORQ_N = 1'b1; WR_N = 1'b1; M1_N = 1'b1; A15 = 1'b0; A14 = 1'b1;
    endtask

    // spoil: 0 clean write, 1 M1_N low, 2 A15 high, 3 A14 low, 4 read cycle
    task automatic bus_write(input logic [7:0] d, input int spoil);
        IORQ_N = 1'b0;
        WR_N   = (spoil == 4);
        M1_N   = (spoil != 1);
        A15    = (spoil == 2);
        A14    = (spoil != 3);
        D      = d;
    endtask

    // Inputs are set at a negedge; outputs are checked at the following one.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("outputs", {4'd0, dut_vec()}, {4'd0, exp_vec(1'b1)});
        chk("outputs_ramdis", {4'd0, dut0_vec()}, {4'd0, exp_vec(1'b0)});
    endtask

    typedef struct {
        logic [7:0] d;
        logic [4:0] pen;
        logic       ink_we;
        logic [4:0] ink_addr;
        logic [4:0] ink_data;
        logic       lrom, hrom, irq, ram_we;
        logic [5:0] ram_cfg;
    } vec_t;

    vec_t vt[10];

    initial begin
        int cnt, cnt0, hold;

        vt[0] = '{8'h10, 5'd16, 1'b0, 5'd0,  5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00};
        vt[1] = '{8'h54, 5'd16, 1'b1, 5'd16, 5'h14, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00};
        vt[2] = '{8'h8D, 5'd16, 1'b0, 5'd0,  5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00};
        vt[3] = '{8'h9C, 5'd16, 1'b0, 5'd0,  5'h00, 1'b1, 1'b1, 1'b1, 1'b0, 6'h00};
        vt[4] = '{8'h8C, 5'd16, 1'b0, 5'd0,  5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00};
        vt[5] = '{8'h07, 5'd7,  1'b0, 5'd0,  5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00};
        vt[6] = '{8'h5F, 5'd7,  1'b1, 5'd7,  5'h1F, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00};
        vt[7] = '{8'hC5, 5'd7,  1'b0, 5'd0,  5'h00, 1'b1, 1'b1, 1'b0, 1'b1, 6'h05};
        vt[8] = '{8'h80, 5'd7,  1'b0, 5'd0,  5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h05};
        vt[9] = '{8'h3A, 5'd16, 1'b0, 5'd0,  5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h05};

        // Clock/reset
        RESET_N = 1'b0; HSYNC_I = 1'b0; D = 8'h00;
        bus_idle();
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {4'd0, dut_vec()}, 32'd0);
        RESET_N = 1'b1;
        cycle();

        // Table of single writes, checked on the clk after each event
        foreach (vt[i]) begin
            bus_write(vt[i].d, 0);
            cycle();
            chk("tbl_pen", PEN, vt[i].pen);
            chk("tbl_ink_we", INK_WE, vt[i].ink_we);
            if (vt[i].ink_we) begin
                chk("tbl_ink_addr", INK_ADDR, vt[i].ink_addr);
                chk("tbl_ink_data", INK_DATA, vt[i].ink_data);
            end
            chk("tbl_lrom", LROM_DIS, vt[i].lrom);
            chk("tbl_hrom", HROM_DIS, vt[i].hrom);
            chk("tbl_irq", IRQ_RESET, vt[i].irq);
            chk("tbl_ram_we", RAM_WE, vt[i].ram_we);
            chk("tbl_ram_cfg", RAM_CFG, vt[i].ram_cfg);
            chk("tbl_mode", MODE, 2'd0);
            bus_idle();
            cycle();
            chk("tbl_strobes_low", {INK_WE, IRQ_RESET, RAM_WE}, 3'b000);
        end

        // Mode waits for an HSYNC rising edge and loads only once per edge
        bus_write(8'h8D, 0); cycle(); bus_idle();
        repeat (3) cycle();
        chk("mode_before_hsync", MODE, 2'd0);
        HSYNC_I = 1'b1; cycle();
        chk("mode_at_hsync", MODE, 2'd1);
        bus_write(8'h83, 0); cycle(); bus_idle();
        repeat (19) cycle();
        chk("mode_hsync_held", MODE, 2'd1);
        HSYNC_I = 1'b0; repeat (2) cycle();

        // Write on the same clk as the HSYNC edge: old pending value wins
        bus_write(8'h81, 0); cycle(); bus_idle(); cycle();
        bus_write(8'h82, 0); HSYNC_I = 1'b1; cycle();
        chk("mode_same_clk", MODE, 2'd1);
        bus_idle(); cycle();
        HSYNC_I = 1'b0; repeat (2) cycle();
        chk("mode_deferred_hold", MODE, 2'd1);
        HSYNC_I = 1'b1; cycle();
        chk("mode_next_hsync", MODE, 2'd2);
        HSYNC_I = 1'b0; cycle();

        // Long strobe gives a single RAM_WE; disabled instance ignores it
        bus_write(8'hC0, 0); cycle(); bus_idle(); cycle();
        cnt = 0; cnt0 = 0;
        bus_write(8'hC5, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(); cnt += int'(RAM_WE); cnt0 += int'(RAM_WE_0);
        end
        bus_idle(); cycle(); cnt += int'(RAM_WE); cnt0 += int'(RAM_WE_0);
        chk("ram_we_pulses", cnt, 1);
        chk("ram_cfg_held", RAM_CFG, 6'h05);
        chk("ram_we_pulses_dis", cnt0, 0);
        chk("ram_cfg_dis", RAM_CFG_0, 6'h00);

        // Interrupt acknowledge, wrong address and reads are not writes
        for (int s = 1; s <= 4; s++) begin
            bus_write(8'hC9, s); repeat (3) cycle();
            bus_idle(); cycle();
            chk("spoiled_no_event", {RAM_WE, RAM_CFG}, {1'b0, 6'h05});
        end

        // Random bus traffic and HSYNC activity against the model
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (hold > 0) begin
                hold--;
            end else if ($urandom_range(0, 2) == 0) begin
                bus_write(8'($urandom), ($urandom_range(0, 9) < 8) ? 0 : int'($urandom_range(1, 4)));
                hold = int'($urandom_range(0, 3));
            end else begin
                bus_idle();
            end
            if ($urandom_range(0, 7) == 0) HSYNC_I = ~HSYNC_I;
            cycle();
        end
        bus_idle(); HSYNC_I = 1'b0; repeat (2) cycle();

        // Reset while an ink strobe is high clears it at once
        bus_write(8'h4A, 0); cycle();
        chk("ink_we_before_reset", INK_WE, 1'b1);
        bus_idle();
        #1 RESET_N = 1'b0;
        #1 chk("reset_async_clear", {4'd0, dut_vec()}, 32'd0);
        model_reset();
        @(negedge clk); RESET_N = 1'b1;
        repeat (2) cycle();

        // Reset on the event clk of an ink write: no strobe ever appears
        bus_write(8'h11, 0); cycle(); bus_idle(); cycle();
        bus_write(8'h55, 0);
        #2 RESET_N = 1'b0;
        model_reset();
        cnt = 0;
        @(negedge clk); cnt += int'(INK_WE); bus_idle();
        @(negedge clk); cnt += int'(INK_WE); RESET_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(); cnt += int'(INK_WE);
        end
        chk("ink_we_after_reset", cnt, 0);
        chk("outputs_zero_after_reset", {4'd0, dut_vec()}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ga_reg_ctrl.md
Name: ga_reg_ctrl

Overview:
Configuration controller of the 40010 gate array. Decodes Z80 I/O writes to the gate array port and sequences the resulting state into the rest of the chip:
- pen select and palette (ink) write strobes to the palette RAM;
- ROM disable lines;
- video mode, applied only at the next HSYNC;
- the one-cycle irq_reset pulse consumed by the sync/interrupt generator.
It sits between the CPU bus pins and the sync generator / video datapath, and runs in the main clk domain.

Parameters:
RAM_CFG_EN, 1, when 1 decode command 11 as RAM configuration (6128 style); when 0 ignore command 11 entirely
BORDER_PEN, 16, pen index selected when D[4]=1 in a pen-select write

Ports:
clk  in  1  main system clock
RESET_N  in  1  asynchronous active-low reset
IORQ_N  in  1  Z80 I/O request
WR_N  in  1  Z80 write strobe
M1_N  in  1  Z80 M1; IORQ_N=0 with M1_N=0 is an interrupt acknowledge, never a write
A15  in  1  address bit 15 (must be 0 to select the gate array)
A14  in  1  address bit 14 (must be 1 to select the gate array)
D  in  8  CPU data bus
HSYNC_I  in  1  HSYNC_O from the sync generator
PEN  out  5  currently selected pen, 0..15 or BORDER_PEN
INK_WE  out  1  one-clk palette write strobe
INK_ADDR  out  5  palette address, equal to PEN at the write
INK_DATA  out  5  hardware colour D[4:0]
MODE  out  2  active video mode
LROM_DIS  out  1  lower ROM disable
HROM_DIS  out  1  upper ROM disable
IRQ_RESET  out  1  one-clk pulse to the sync generator irq_reset input
RAM_CFG  out  6  RAM banking configuration D[5:0]
RAM_WE  out  1  one-clk strobe on a RAM_CFG update

Behaviour:
- Reset (asynchronous, RESET_N=0) clears all outputs and internal registers to 0, including the pending mode register and both edge-detect registers.
- Write qualifier wr_act = ~IORQ_N & ~WR_N & M1_N & ~A15 & A14, sampled every clk.
- A write event fires on the clk where wr_act=1 and wr_act_d=0, so exactly one event per I/O cycle however long the strobe is held.
- Decoded registers update on the clk edge following the event clk (1-clk latency). Strobes are high for exactly that one clk.
- Command is selected by D[7:6]:
  - 00 pen select: PEN <= D[4] ? BORDER_PEN : {1'b0, D[3:0]}.
  - 01 ink write: INK_WE=1, INK_ADDR=PEN (value before this event), INK_DATA=D[4:0]. PEN is unchanged.
  - 10 mode/ROM:
    - mode_pend <= D[1:0];
    - LROM_DIS <= D[2] and HROM_DIS <= D[3], both immediately;
    - if D[4]=1, IRQ_RESET=1 for one clk. D[4]=0 produces no pulse.
  - 11 with RAM_CFG_EN=1: RAM_CFG <= D[5:0], RAM_WE=1. With RAM_CFG_EN=0: no effect, no strobe.
- Mode scheduling:
  - On the clk where HSYNC_I=1 and hsync_d=0, MODE <= mode_pend (visible on the next clk).
  - MODE never changes outside an HSYNC rising edge.
- Simultaneous write event and HSYNC edge: MODE loads the mode_pend value from before the write. The new value waits for the following HSYNC. Never forward.
- Back-to-back I/O writes (OUT then OUT) are processed independently. A pen select followed by an ink write uses the new pen.
- IRQ_RESET and INK_WE can never be high together, since each event carries only one command.
- HSYNC_I held high does not reload MODE; there is exactly one load per rising edge.
- RESET_N asserted mid-cycle clears any in-flight strobe immediately. After release, the first event needs a fresh wr_act rising edge.

Decomposition:
- Shared package ga_pkg holds:
  - command encodings CMD_PEN=2'b00, CMD_INK=2'b01, CMD_MODE=2'b10, CMD_RAM=2'b11;
  - the BORDER_PEN default (16);
  - field widths PEN_W=5, INK_W=5, RAM_CFG_W=6.
- One natural sub-module, ga_io_decode: the qualifier, edge detect and command decode. It emits a one-clk cmd_valid together with cmd and data. The parent keeps the registers, the mode scheduling and the strobes.

Test Plan:
- Reset released; OUT &7F00,&10 -> PEN=16 one clk after the event; then OUT &7F00,&54 -> INK_WE=1 for exactly one clk with INK_ADDR=16, INK_DATA=&14.
- OUT &7F00,&8D with HSYNC_I low -> LROM_DIS=1 and HROM_DIS=1 next clk, MODE stays 0; HSYNC_I rising edge -> MODE=1 next clk; HSYNC_I held high 20 clks -> no further change.
- OUT &7F00,&9C -> IRQ_RESET high exactly one clk; OUT &7F00,&8C -> no IRQ_RESET pulse.
- Write with D=&82 on the same clk as the HSYNC_I rising edge, mode_pend=1 beforehand -> MODE=1 at this HSYNC, MODE=2 at the next HSYNC.
- IORQ_N=0, WR_N=0 held 8 clks with A=&7F00, D=&C5 -> single RAM_WE pulse, RAM_CFG=&05. Same stimulus with RAM_CFG_EN=0 -> no RAM_WE, RAM_CFG stays 0. M1_N=0 or A15=1 -> no event.
- RESET_N pulsed low on the clk of an ink write event -> INK_WE never seen high, all outputs 0.
